// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the parametrised Johnson/ring shift counter.
package shift_counter_pkg;

    localparam int unsigned MODE_JOHNSON = 0;
    localparam int unsigned MODE_RING    = 1;

    // Width of the decoded position output for a given register width.
    function automatic int unsigned idx_width(input int unsigned width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/shift_counter_check.sv
// Combinational legality check and position decode for one Johnson or ring state vector.
module shift_counter_check
    import shift_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MODE  = MODE_JOHNSON
) (
    input  logic [WIDTH-1:0]            state,
    output logic                        legal,
    output logic [idx_width(WIDTH)-1:0] idx
);

    localparam int unsigned IW = idx_width(WIDTH);

    int unsigned   ones;
    int unsigned   edges;
    logic [IW-1:0] ring_pos;

    // Population count, count of adjacent-bit transitions, and position of the highest set bit.
    always_comb begin
        ones     = 0;
        edges    = 0;
        ring_pos = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones = ones + 32'(state[i]);
            if (state[i]) ring_pos = IW'(i);
        end
        for (int i = 0; i + 1 < int'(WIDTH); i++) begin
            if (state[i] != state[i+1]) edges = edges + 1;
        end
    end

    // A Johnson state is a single run of ones; its position counts from all-zeros going up.
    always_comb begin
        legal = 1'b0;
        idx   = '0;
        if (MODE == MODE_RING) begin
            legal = (ones == 1);
            idx   = ring_pos;
        end else begin
            legal = (edges <= 1);
            if (state == '0)   idx = '0;
            else if (state[0]) idx = IW'(ones);
            else               idx = IW'(2 * WIDTH - ones);
        end
    end

endmodule

// File: rtl/shift_counter.sv
// Parametrised Johnson / one-hot ring counter with enable, direction, checked
// parallel load, wrap pulse, decoded index and illegal-state self-correction.
module shift_counter
    import shift_counter_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter int unsigned      MODE  = MODE_JOHNSON,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        dir,
    input  logic                        load,
    input  logic [WIDTH-1:0]            load_val,
    output logic [WIDTH-1:0]            q,
    output logic [idx_width(WIDTH)-1:0] idx,
    output logic                        tc,
    output logic                        err
);

    localparam int unsigned IW = idx_width(WIDTH);

    // Elaboration-time legality of the reset/correction value.
    function automatic bit init_legal(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        if (MODE == MODE_RING) begin
            for (int i = 0; i < int'(WIDTH); i++) n = n + 32'(v[i]);
            return n == 1;
        end
        for (int i = 0; i + 1 < int'(WIDTH); i++) begin
            if (v[i] != v[i+1]) n = n + 1;
        end
        return n <= 1;
    endfunction

    if (WIDTH < 2) begin : g_bad_width
        $error("shift_counter: WIDTH must be at least 2");
    end
    if (MODE > MODE_RING) begin : g_bad_mode
        $error("shift_counter: MODE must be 0 (Johnson) or 1 (ring)");
    end
    if (!init_legal(INIT)) begin : g_bad_init
        $error("shift_counter: INIT is not a legal state for MODE");
    end

    logic             q_legal;
    logic             load_legal;
    logic [IW-1:0]    load_idx_unused;
    logic             inv;
    logic [WIDTH-1:0] nxt;

    shift_counter_check #(.WIDTH(WIDTH), .MODE(MODE)) u_check_q (
        .state (q),
        .legal (q_legal),
        .idx   (idx)
    );

    shift_counter_check #(.WIDTH(WIDTH), .MODE(MODE)) u_check_load (
        .state (load_val),
        .legal (load_legal),
        .idx   (load_idx_unused)
    );

    // Johnson inverts the bit wrapping around the end; ring passes it straight through.
    assign inv = 1'(MODE == MODE_JOHNSON);
    assign nxt = dir ? {q[WIDTH-2:0], q[WIDTH-1] ^ inv}
                     : {q[0] ^ inv, q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= INIT;
            tc  <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            tc <= 1'b0;
            if (load_legal) begin
                q   <= load_val;
                err <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end else if (!q_legal) begin
            q   <= INIT;
            tc  <= 1'b0;
            err <= 1'b1;
        end else if (en) begin
            q   <= nxt;
            tc  <= (nxt == INIT);
            err <= 1'b0;
        end else begin
            tc  <= 1'b0;
            err <= 1'b0;
        end
    end

endmodule

// File: doc/shift_counter.md
Name: shift_counter

Overview:
- Parametrised successor of the fixed 4-bit Johnson counter.
- Generates Johnson (twisted-ring) or one-hot ring sequences of any width.
- Adds enable, up/down direction, parallel load, wrap (terminal-count) pulse, decoded state index, and illegal-state detection with self-correction.
- Used as a phase/sequence generator and as a glitch-free decoded counter in the counter library.

Parameters:
- WIDTH, 4: register width in bits; must be >= 2.
- MODE, 0: 0 = Johnson (sequence length 2*WIDTH), 1 = ring (sequence length WIDTH).
- INIT, 1: reset/correction value, WIDTH bits. Must be a legal state for MODE; an illegal value is an elaboration error.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  step enable.
- dir  in  1  1 = up (shift toward MSB), 0 = down.
- load  in  1  parallel-load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  counter state (registered).
- idx  out  IW  decoded position of q. IW = $clog2(2*WIDTH). Combinational from q.
- tc  out  1  registered one-cycle pulse: a step has just landed on INIT.
- err  out  1  registered one-cycle pulse: illegal state, or rejected load.

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-low.
- Reset: rst==0 at a rising clk edge sets q=INIT, tc=0, err=0. Reset overrides en, load and correction.
- Priority, per edge: reset > load > illegal-state correction > step > hold.
- Johnson next state:
  - up: {q[W-2:0], ~q[W-1]}
  - down: {~q[0], q[W-1:1]}
- Ring next state:
  - up: {q[W-2:0], q[W-1]}
  - down: {q[0], q[W-1:1]}
- Legality:
  - Johnson: q is legal iff at most one index i (0..W-2) has q[i] != q[i+1].
  - Ring: q is legal iff popcount(q) == 1.
- Load:
  - load=1 with legal load_val: q <= load_val; err <= 0; tc <= 0.
  - load=1 with illegal load_val: q unchanged; err <= 1 for one cycle.
  - en is ignored in any cycle where load=1.
- Correction: if load=0 and q is illegal, q <= INIT and err <= 1 for one cycle, regardless of en.
- Step: load=0, q legal, en=1: q <= next state for dir. tc <= 1 iff the next state equals INIT; otherwise tc <= 0.
- Hold: en=0: q holds; tc <= 0; err <= 0.
- err and tc each last exactly one cycle per event. Back-to-back events give back-to-back pulses.
- idx, Johnson mode (index relative to all-zeros):
  - q==0 gives 0.
  - q[0]==1 gives popcount(q).
  - otherwise gives 2*WIDTH - popcount(q).
- idx, ring mode: bit position of the single 1.
- idx is don't-care while q is illegal.
- Direction may change on any cycle with no penalty. Wrap-around is continuous in both directions.
- Latency: q, tc and err update one edge after inputs are sampled. idx adds no latency.

Decomposition:
- Package shift_counter_pkg:
  - MODE_JOHNSON=0, MODE_RING=1 constants.
  - idx_width(WIDTH) function returning $clog2(2*WIDTH).
- One combinational sub-module, shift_counter_check(WIDTH, MODE):
  - inputs: a state vector.
  - outputs: legal flag and idx.
  - instantiated twice: once on q (correction and idx), once on load_val (load acceptance).

Test Plan:
- Reset (W=4, MODE=0, INIT=0001): hold rst=0 for one edge with en=1, load=1 -> q=0001, idx=1, tc=0, err=0.
- Up count: en=1, dir=1 for 8 edges from 0001 -> 0011,0111,1111,1110,1100,1000,0000,0001; tc=1 only after the 8th edge; idx follows 2,3,4,5,6,7,0,1.
- Down count and reversal: from 0001, dir=0 for 3 edges -> 0000,1000,1100; then dir=1 for 1 edge -> 1000; with en=0 for 3 edges q holds 1000.
- Load: load_val=1100, load=1 -> q=1100, idx=6, err=0. Then load_val=0101 -> q stays 1100, err=1 for exactly one cycle.
- Correction: deposit q=1010 with en=0 -> next edge q=0001, err=1; following edge err=0.
- Ring mode (MODE=1, W=4, INIT=0001): en=1, dir=1 for 4 edges -> 0010,0100,1000,0001, tc=1 after the 4th edge. Deposit q=0011 -> q=0001, err=1. rst=0 mid-count -> q=0001 on that edge.
